// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared types and constants for the PWM output stage.
//   pwm_state_e     : run-control FSM states (idle, run, stop-at-wrap)
//   PWM_PERIOD_MAX  : last period-counter value; a period is 255 ticks
//   slew_toward()   : moves a duty code toward a target by a bounded step.
//                     It is used only when PWM_SLEW_LIMIT_EN is defined.
// ----------------------------------------------------------------------------
package pwm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } pwm_state_e;

    localparam logic [7:0] PWM_PERIOD_MAX = 8'd254;

    // Step cur toward tgt by at most step. The result never overshoots tgt,
    // so it stays inside 0..255 without explicit clamping.
    function automatic logic [7:0] slew_toward(input logic [7:0]  cur,
                                               input logic [7:0]  tgt,
                                               input int unsigned step);
        int unsigned c;
        int unsigned t;
        c = {24'd0, cur};
        t = {24'd0, tgt};
        if (t > c + step) begin
            return 8'(c + step);
        end else if (c > t + step) begin
            return 8'(c - step);
        end else begin
            return tgt;
        end
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// ----------------------------------------------------------------------------
// pwm_prescaler
// Divides clk down to the PWM counter tick rate.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   run  : count enable; the counter is held at 0 while low
//   tick : one-clock pulse when the count wraps from PRESCALE-1 to 0
// ----------------------------------------------------------------------------
module pwm_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int unsigned     CntW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_output_stage.sv
// ----------------------------------------------------------------------------
// pwm_output_stage
// 8-bit PWM generator with a shadowed duty register that is only applied at
// period boundaries, plus an enable-driven IDLE/RUN/STOP run controller.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset, overrides everything
//   enable       : request to run PWM; dropping it finishes the current period
//   duty_in      : requested duty code (0 = always low, 255 = always high)
//   duty_valid   : duty_in valid; accepted when duty_ready is also high
//   duty_ready   : shadow register free (no update pending)
//   pwm_out      : registered waveform, high while period count < duty_active
//   period_start : one-clock pulse at the first tick of each running period
//   duty_active  : duty code currently applied
// Build option: define PWM_SLEW_LIMIT_EN to limit duty_active changes to
// SLEW_STEP per period; otherwise the shadow value loads in one step.
// ----------------------------------------------------------------------------
module pwm_output_stage
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE  = 4,
    parameter int unsigned SLEW_STEP = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] duty_in,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty_active
);

    pwm_state_e state_q, state_d;
    logic [7:0] period_cnt_q, period_cnt_d;
    logic [7:0] shadow_q, shadow_d;
    logic       pending_q, pending_d;
    logic [7:0] duty_active_q, duty_active_d;
    logic       pwm_out_q, pwm_out_d;
    logic       period_start_q, period_start_d;

    logic run;
    logic tick;
    logic wrap;
    logic accept;
    logic apply;

`ifdef PWM_SLEW_LIMIT_EN
    logic [7:0] slewed;
`else
    logic unused_slew_step;
    assign unused_slew_step = ^SLEW_STEP;
`endif

    assign run    = (state_q != StIdle);
    assign wrap   = tick && (period_cnt_q == PWM_PERIOD_MAX);
    assign accept = duty_valid && !pending_q;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .tick (tick)
    );

    // Run control. apply marks the points where the shadow may reach
    // duty_active: every wrap while counting, and entry into RUN.
    always_comb begin
        state_d        = state_q;
        period_start_d = 1'b0;
        apply          = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d        = StRun;
                    period_start_d = 1'b1;
                    apply          = 1'b1;
                end
            end
            StRun: begin
                apply = wrap;
                if (!enable) begin
                    // A drop that lands on the wrap has already finished its period.
                    state_d = wrap ? StIdle : StStop;
                end else if (wrap) begin
                    period_start_d = 1'b1;
                end
            end
            StStop: begin
                apply = wrap;
                if (enable) begin
                    state_d        = StRun;
                    period_start_d = wrap;
                end else if (wrap) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        period_cnt_d = period_cnt_q;
        if (state_q == StIdle) begin
            period_cnt_d = 8'd0;
        end else if (tick) begin
            period_cnt_d = (period_cnt_q == PWM_PERIOD_MAX) ? 8'd0 : period_cnt_q + 8'd1;
        end
    end

    // Shadow path. An accept can only happen while nothing is pending, so an
    // accept coinciding with apply never loads mid-period; it waits a wrap.
    always_comb begin
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        duty_active_d = duty_active_q;
`ifdef PWM_SLEW_LIMIT_EN
        slewed        = slew_toward(duty_active_q, shadow_q, SLEW_STEP);
`endif
        if (apply && pending_q) begin
`ifdef PWM_SLEW_LIMIT_EN
            duty_active_d = slewed;
            pending_d     = (slewed != shadow_q);
`else
            duty_active_d = shadow_q;
            pending_d     = 1'b0;
`endif
        end
        if (accept) begin
            shadow_d  = duty_in;
            pending_d = 1'b1;
        end
    end

    // Count 0..254 against duty 255 keeps the output high for the full period.
    always_comb begin
        pwm_out_d = run && (period_cnt_q < duty_active_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            period_cnt_q   <= 8'd0;
            shadow_q       <= 8'd0;
            pending_q      <= 1'b0;
            duty_active_q  <= 8'd0;
            pwm_out_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            period_cnt_q   <= period_cnt_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            duty_active_q  <= duty_active_d;
            pwm_out_q      <= pwm_out_d;
            period_start_q <= period_start_d;
        end
    end

    assign duty_ready   = !pending_q;
    assign pwm_out      = pwm_out_q;
    assign period_start = period_start_q;
    assign duty_active  = duty_active_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// ----------------------------------------------------------------------------
// tb_pwm_output_stage
// Bench for pwm_output_stage with PRESCALE=1 (one tick per clock, 255-clock
// periods). Inputs are driven and outputs sampled on the falling edge.
// Define PWM_SLEW_LIMIT_EN to run the slew-limited step sequence instead.
// ----------------------------------------------------------------------------
module tb_pwm_output_stage;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_active;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] duty;
        logic [7:0] exp_active;
        int         exp_highs;
    } vec_t;

    typedef struct {
        logic [7:0] active;
        int         highs;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];

    pwm_output_stage #(
        .PRESCALE  (1),
        .SLEW_STEP (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual timeout, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_duty(input logic [7:0] d);
        int n = 0;
        while (!duty_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!duty_ready) check("ready_timeout", int'(duty_ready), 1);
        duty_in    = d;
        duty_valid = 1'b1;
        @(negedge clk);
        duty_valid = 1'b0;
    endtask

    task automatic wait_ps();
        int n = 0;
        @(negedge clk);
        while (!period_start && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!period_start) check("ps_timeout", int'(period_start), 1);
    endtask

    // Called on a period_start sample; ends on the next one.
    task automatic measure(output int highs, output int early_ps, output int end_ps);
        highs    = 0;
        early_ps = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            if (k < 255) early_ps += int'(period_start);
        end
        end_ps = int'(period_start);
    endtask

    task automatic measure_and_score(input string name);
        int   highs, early, endp;
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        check({name, "_active"}, int'(duty_active), int'(e.active));
        measure(highs, early, endp);
        check({name, "_highs"}, highs, e.highs);
        check({name, "_ps_mid"}, early, 0);
        check({name, "_ps_end"}, endp, 1);
    endtask

    initial begin
        int highs, early, endp, ps_cnt, not_held;

        rst        = 1'b1;
        enable     = 1'b0;
        duty_in    = 8'd0;
        duty_valid = 1'b0;
        cycles(3);
        check("rst_ready", int'(duty_ready), 1);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_ps", int'(period_start), 0);
        check("rst_active", int'(duty_active), 0);
        rst = 1'b0;
        cycles(2);

`ifdef PWM_SLEW_LIMIT_EN
        begin
            logic [7:0] steps[7];
            steps = '{8'd16, 8'd32, 8'd48, 8'd64, 8'd80, 8'd96, 8'd100};
            enable = 1'b1;
            @(negedge clk);
            check("slew_entry_ps", int'(period_start), 1);
            send_duty(8'd100);
            for (int i = 0; i < 7; i++) begin
                wait_ps();
                check($sformatf("slew_step%0d", i), int'(duty_active), int'(steps[i]));
                check($sformatf("slew_ready%0d", i), int'(duty_ready), (i == 6) ? 1 : 0);
            end
        end
`else
        vecs[0] = '{duty: 8'd0,   exp_active: 8'd0,   exp_highs: 0};
        vecs[1] = '{duty: 8'd255, exp_active: 8'd255, exp_highs: 255};
        vecs[2] = '{duty: 8'd1,   exp_active: 8'd1,   exp_highs: 1};
        vecs[3] = '{duty: 8'd254, exp_active: 8'd254, exp_highs: 254};
        vecs[4] = '{duty: 8'd128, exp_active: 8'd128, exp_highs: 128};
        vecs[5] = '{duty: 8'd50,  exp_active: 8'd50,  exp_highs: 50};

        // Duty accepted in IDLE is held pending until RUN entry.
        send_duty(8'd64);
        sb.push_back('{active: 8'd64, highs: 64});
        check("idle_pending_ready", int'(duty_ready), 0);
        cycles(5);
        check("idle_active_held", int'(duty_active), 0);
        check("idle_pwm_low", int'(pwm_out), 0);
        enable = 1'b1;
        @(negedge clk);
        check("entry_ps", int'(period_start), 1);
        check("entry_ready", int'(duty_ready), 1);
        measure_and_score("d64_p1");
        sb.push_back('{active: 8'd64, highs: 64});
        measure_and_score("d64_p2");

        foreach (vecs[i]) begin
            send_duty(vecs[i].duty);
            sb.push_back('{active: vecs[i].exp_active, highs: vecs[i].exp_highs});
            check($sformatf("vec%0d_not_early", i), int'(duty_active), int'(vecs[i - 0 > 0 ? i - 1 : 0].exp_active) * ((i > 0) ? 1 : 0) + ((i == 0) ? 64 : 0));
            wait_ps();
            measure_and_score($sformatf("vec%0d", i));
        end

        // Running at 50: a mid-period request waits for the wrap.
        cycles(20);
        send_duty(8'd200);
        check("mid_ready_low", int'(duty_ready), 0);
        not_held = 0;
        ps_cnt   = 0;
        while (!period_start && ps_cnt < 400) begin
            if (duty_active != 8'd50 || duty_ready) not_held++;
            @(negedge clk);
            ps_cnt++;
        end
        check("mid_held_until_wrap", not_held, 0);
        check("mid_applied_at_wrap", int'(duty_active), 200);
        check("mid_ready_after_wrap", int'(duty_ready), 1);

        // Drop enable at count 100: period completes, then IDLE.
        highs  = 0;
        ps_cnt = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            if (k < 255) ps_cnt += int'(period_start);
            if (k == 100) enable = 1'b0;
        end
        check("stop_highs", highs, 200);
        check("stop_no_mid_ps", ps_cnt, 0);
        check("stop_final_no_ps", int'(period_start), 0);
        highs  = 0;
        ps_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            highs  += int'(pwm_out);
            ps_cnt += int'(period_start);
        end
        check("idle_pwm_highs", highs, 0);
        check("idle_ps_count", ps_cnt, 0);

        // Drop at 100, return at 200: stays in the same period.
        enable = 1'b1;
        @(negedge clk);
        check("reenter_ps", int'(period_start), 1);
        highs  = 0;
        ps_cnt = 0;
        for (int k = 1; k <= 255; k++) begin
            @(negedge clk);
            highs += int'(pwm_out);
            if (k < 255) ps_cnt += int'(period_start);
            if (k == 100) enable = 1'b0;
            if (k == 200) enable = 1'b1;
        end
        check("rerun_highs", highs, 200);
        check("rerun_no_restart", ps_cnt, 0);
        check("rerun_wrap_ps", int'(period_start), 1);

        // Reset mid-period with an update pending.
        cycles(30);
        send_duty(8'd10);
        check("rst_pre_pending", int'(duty_ready), 0);
        cycles(20);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pwm", int'(pwm_out), 0);
        check("midrst_ps", int'(period_start), 0);
        check("midrst_active", int'(duty_active), 0);
        check("midrst_ready", int'(duty_ready), 1);
        enable = 1'b0;
        rst    = 1'b0;
        ps_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            ps_cnt += int'(period_start);
        end
        check("postrst_idle_ps", ps_cnt, 0);
        enable = 1'b1;
        @(negedge clk);
        check("postrst_entry_ps", int'(period_start), 1);
        sb.push_back('{active: 8'd0, highs: 0});
        measure_and_score("postrst");
        check("sb_drained", sb.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_output_stage.md
PWM_OUTPUT_STAGE -- requirements
Module: pwm_output_stage

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: clocks per PWM counter tick (range 1..256).
REQ-002 SHALL have parameter SLEW_STEP, default 16: maximum duty change per period when slew limiting is compiled in.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  request to run PWM.
REQ-006 SHALL have port duty_in  input  8  requested duty, the controller output code.
REQ-007 SHALL have port duty_valid  input  1  duty_in is valid this cycle.
REQ-008 SHALL have port duty_ready  output  1  shadow register free; duty_in is accepted when duty_valid and duty_ready are both high.
REQ-009 SHALL have port pwm_out  output  1  registered PWM waveform.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse at the first tick of each period.
REQ-011 SHALL have port duty_active  output  8  duty currently being applied.

Function
REQ-012 Prescaler SHALL count 0..PRESCALE-1 and assert an internal tick when it wraps; it holds at 0 outside RUN/STOP.
REQ-013 Period counter SHALL count 0..254 on ticks (255 ticks per period) and wrap from 254 to 0.
REQ-014 pwm_out SHALL be registered as (period counter < duty_active), giving 1-clock latency.
REQ-015 Duty code 0 SHALL give a constant low output, and code 255 SHALL give a constant high output.
REQ-016 Shadow path: on accept, duty_in SHALL be written to the shadow and pending set; duty_ready SHALL equal !pending.
REQ-017 At a period wrap with pending=1, duty_active SHALL take the shadow value and pending SHALL clear, so duty_ready rises on the next cycle.
REQ-018 An accept in the same cycle as a wrap with pending=0 SHALL go to the shadow and be applied at the following wrap, never mid-period.
REQ-019 FSM states SHALL be IDLE, RUN and STOP.
REQ-020 In IDLE, pwm_out SHALL be 0 and the counters SHALL be held at 0.
REQ-021 IDLE->RUN SHALL occur when enable=1; on entry, duty_active loads the shadow if pending, and period_start pulses.
REQ-022 RUN->STOP SHALL occur when enable=0; the current period completes unchanged.
REQ-023 STOP->IDLE SHALL occur at the wrap; STOP->RUN SHALL occur if enable returns to 1 before the wrap, with no counter restart.
REQ-024 period_start SHALL pulse for one clock on each wrap in RUN; no pulse on the final STOP wrap.
REQ-025 Accepts SHALL be allowed in every state, and pending updates in IDLE are applied at the next RUN entry.

Reset
REQ-026 rst SHALL take priority over all inputs, including mid-period.
REQ-027 On reset: state=IDLE, counters=0, shadow=0, pending=0, duty_active=0, pwm_out=0, period_start=0, duty_ready=1.

Configuration
REQ-028 Macro PWM_SLEW_LIMIT_EN SHALL compile slew limiting in or out.
REQ-029 When PWM_SLEW_LIMIT_EN is defined, at each wrap duty_active SHALL move toward the shadow by at most SLEW_STEP, saturating within 0..255; pending clears only when duty_active equals the shadow.
REQ-030 When PWM_SLEW_LIMIT_EN is not defined, the full value SHALL load in one wrap, per REQ-017.

Structure
REQ-031 Shared package pwm_pkg SHALL hold the FSM state typedef and the constant PWM_PERIOD_MAX=254.
REQ-032 The prescaler SHALL be a sub-module, pwm_prescaler, with inputs clk, rst, run and output tick.

Verification
REQ-033 PRESCALE=1, enable=1, duty 64 accepted in IDLE -> pwm_out high for 64 of each 255 clocks; period_start every 255 clocks.
REQ-034 Duty 0, then duty 255 -> constant low, then constant high after the next wrap, with no glitch.
REQ-035 Accept 200 mid-period while running at 50 -> duty_active stays 50 until the wrap; duty_ready low until the cycle after the wrap.
REQ-036 Drop enable at counter 100 -> output continues to the wrap, then IDLE with pwm_out=0; re-enable at counter 200 -> stays in RUN, no restart.
REQ-037 Assert rst mid-period with pending=1 -> all outputs match the reset values on the next clock; duty_ready=1.
REQ-038 With PWM_SLEW_LIMIT_EN and SLEW_STEP=16, step 0->100 -> duty_active 16, 32, 48, 64, 80, 96, 100 at successive wraps.
